// File: rtl/csi2_pkt_hdr_enc.sv
// CSI-2 packet header encoder: builds the 32-bit packet header (DI + 6-bit ECC)
// and streams the payload words behind it through a single output register.
module csi2_pkt_hdr_enc #(
   parameter logic [5:0] LONG_DT_MIN = 6'h10
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        hdr_valid_i,
   output logic        hdr_ready_o,
   input  logic [1:0]  hdr_vc_i,
   input  logic [5:0]  hdr_dt_i,
   input  logic [15:0] hdr_wc_i,
   input  logic [31:0] pld_data_i,
   input  logic        pld_valid_i,
   output logic        pld_ready_o,
   output logic [31:0] data_o,
   output logic [3:0]  keep_o,
   output logic        last_o,
   output logic        valid_o,
   input  logic        ready_i
);

   typedef enum logic [1:0] {
      IDLE,
      HDR_OUT,
      PLD
   } state_t;

   state_t      state_q;
   logic [13:0] cnt_q;
   logic [1:0]  wc_lsb_q;
   logic [31:0] data_q;
   logic [3:0]  keep_q;
   logic        last_q;
   logic        valid_q;

   logic        free;
   logic        hdr_fire;
   logic        pld_fire;
   logic [23:0] di;
   logic        hdr_last;
   logic [13:0] cnt_load;
   logic [3:0]  final_keep;

   function automatic logic [5:0] ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
           ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
           ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
           ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
           ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
           ^ d[20] ^ d[22] ^ d[23];
      p[5] = (^d[19:10]) ^ d[21] ^ d[22] ^ d[23];
      return p;
   endfunction

   // Output register accepts a new word when empty or being drained this cycle.
   assign free        = !valid_q || ready_i;
   assign hdr_ready_o = rst_n_i && (state_q == IDLE) && free;
   assign pld_ready_o = rst_n_i && (state_q == PLD) && free;
   assign hdr_fire    = hdr_valid_i && hdr_ready_o;
   assign pld_fire    = pld_valid_i && pld_ready_o;

   assign di       = {hdr_wc_i, hdr_vc_i, hdr_dt_i};
   assign hdr_last = (hdr_dt_i < LONG_DT_MIN) || (hdr_wc_i == 16'd0);
   // ceil(wc/4) kept to 14 bits; wc >= 65533 loads 0, which wraps through the
   // full 16384-word count before reaching 1.
   assign cnt_load = hdr_wc_i[15:2] + 14'(|hdr_wc_i[1:0]);

   always_comb begin
      final_keep = 4'hF;
      case (wc_lsb_q)
         2'b01:   final_keep = 4'h1;
         2'b10:   final_keep = 4'h3;
         2'b11:   final_keep = 4'h7;
         default: final_keep = 4'hF;
      endcase
   end

   // NOTE: every register here, including the output word, is cleared by the
   // asynchronous reset so a dropped packet leaves no stale data on data_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wc_lsb_q <= '0;
         data_q   <= '0;
         keep_q   <= 4'h0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the later fire branches
         // override this default drop of valid_q within the same edge.
         if (free) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (hdr_fire) begin
                  data_q   <= {2'b00, ecc6(di), di};
                  keep_q   <= 4'hF;
                  last_q   <= hdr_last;
                  valid_q  <= 1'b1;
                  wc_lsb_q <= hdr_wc_i[1:0];
                  cnt_q    <= hdr_last ? 14'd0 : cnt_load;
                  state_q  <= hdr_last ? IDLE : HDR_OUT;
               end
            end
            HDR_OUT: begin
               if (free) begin
                  state_q <= PLD;
               end
            end
            PLD: begin
               if (pld_fire) begin
                  data_q  <= pld_data_i;
                  valid_q <= 1'b1;
                  last_q  <= (cnt_q == 14'd1);
                  keep_q  <= (cnt_q == 14'd1) ? final_keep : 4'hF;
                  cnt_q   <= cnt_q - 14'd1;
                  if (cnt_q == 14'd1) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_o  = data_q;
   assign keep_o  = keep_q;
   assign last_o  = last_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_csi2_pkt_hdr_enc.sv
// Self-checking bench for csi2_pkt_hdr_enc: scoreboard of expected output words
// filled at input handshakes, drained as the DUT presents words downstream.
module tb_csi2_pkt_hdr_enc;

   localparam logic [5:0] LONG_DT_MIN = 6'h10;

   // ECC contribution of each DI bit (column of the parity-check matrix).
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
   };

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      bit          is_hdr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hdr_valid_i;
   logic        hdr_ready_o;
   logic [1:0]  hdr_vc_i;
   logic [5:0]  hdr_dt_i;
   logic [15:0] hdr_wc_i;
   logic [31:0] pld_data_i;
   logic        pld_valid_i;
   logic        pld_ready_o;
   logic [31:0] data_o;
   logic [3:0]  keep_o;
   logic        last_o;
   logic        valid_o;
   logic        ready_i;

   exp_t        sb[$];
   logic [36:0] out_words[$];
   int          out_cyc[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   logic [3:0]  exp_keep;
   logic        exp_last;
   bit          hold_q = 1'b0;
   logic [36:0] prev_word;

   csi2_pkt_hdr_enc #(.LONG_DT_MIN(LONG_DT_MIN)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .hdr_valid_i (hdr_valid_i),
      .hdr_ready_o (hdr_ready_o),
      .hdr_vc_i    (hdr_vc_i),
      .hdr_dt_i    (hdr_dt_i),
      .hdr_wc_i    (hdr_wc_i),
      .pld_data_i  (pld_data_i),
      .pld_valid_i (pld_valid_i),
      .pld_ready_o (pld_ready_o),
      .data_o      (data_o),
      .keep_o      (keep_o),
      .last_o      (last_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] ecc_model(input logic [23:0] di);
      logic [5:0] p = '0;
      for (int i = 0; i < 24; i++) begin
         if (di[i]) p ^= ECC_COL[i];
      end
      return p;
   endfunction

   function automatic logic [31:0] hdr_model(input logic [1:0] vc, input logic [5:0] dt,
                                             input logic [15:0] wc);
      logic [23:0] di = {wc, vc, dt};
      return {2'b00, ecc_model(di), di};
   endfunction

   function automatic logic [3:0] keep_model(input logic [15:0] wc);
      case (wc[1:0])
         2'b00:   return 4'hF;
         2'b01:   return 4'h1;
         2'b10:   return 4'h3;
         default: return 4'h7;
      endcase
   endfunction

   // Monitor: compare words leaving the DUT, queue expectations at input handshakes.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_q = 1'b0;
      end else begin
         cyc++;
         if (hold_q) begin
            check("hold_valid", valid_o, 1);
            check("hold_word", {data_o, keep_o, last_o}, prev_word);
         end
         if (valid_o && ready_i) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("data", data_o, e.data);
               check("keep", keep_o, e.keep);
               check("last", last_o, e.last);
               if (e.is_hdr) check("ecc_syndrome", ecc_model(data_o[23:0]) ^ data_o[29:24], 0);
            end
            out_words.push_back({data_o, keep_o, last_o});
            out_cyc.push_back(cyc);
         end
         if (hdr_valid_i && hdr_ready_o) begin
            e.data   = hdr_model(hdr_vc_i, hdr_dt_i, hdr_wc_i);
            e.keep   = 4'hF;
            e.last   = (hdr_dt_i < LONG_DT_MIN) || (hdr_wc_i == 16'd0);
            e.is_hdr = 1'b1;
            sb.push_back(e);
         end
         if (pld_valid_i && pld_ready_o) begin
            e.data   = pld_data_i;
            e.keep   = exp_keep;
            e.last   = exp_last;
            e.is_hdr = 1'b0;
            sb.push_back(e);
         end
         hold_q    = valid_o && !ready_i;
         prev_word = {data_o, keep_o, last_o};
      end
   end

   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) ready_i = 1'b1;
      else if (ready_mode == 1) ready_i = ($urandom_range(0, 3) != 0);
   end

   task automatic wait_hs(input bit is_hdr, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (is_hdr ? hdr_ready_o : pld_ready_o) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            break;
         end
      end
   endtask

   task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input bit stall);
      bit ok;
      int nwords;
      hdr_vc_i    = vc;
      hdr_dt_i    = dt;
      hdr_wc_i    = wc;
      hdr_valid_i = 1'b1;
      wait_hs(1'b1, ok);
      hdr_valid_i = 1'b0;
      check("hdr_accept", ok, 1);
      if (ok && dt >= LONG_DT_MIN && wc != 16'd0) begin
         nwords = (int'(wc) + 3) / 4;
         for (int k = 0; k < nwords; k++) begin
            pld_data_i  = $urandom;
            exp_last    = (k == nwords - 1);
            exp_keep    = exp_last ? keep_model(wc) : 4'hF;
            pld_valid_i = 1'b1;
            if (stall && k == 1) begin
               ready_i = 1'b0;
               repeat (5) begin
                  @(negedge clk);
                  check("stall_pld_ready", pld_ready_o, 0);
                  check("stall_valid", valid_o, 1);
               end
               @(posedge clk);
               #1;
               ready_i = 1'b1;
            end
            wait_hs(1'b0, ok);
            if (!ok) begin
               check("pld_accept", ok, 1);
               break;
            end
         end
         pld_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0 && !valid_o) begin
            done = 1'b1;
            break;
         end
      end
      check("drain", done, 1);
   endtask

   task automatic expect_word(input string tag, input int idx, input logic [36:0] exp);
      check({tag, "_present"}, out_words.size() > idx, 1);
      if (out_words.size() > idx) check(tag, out_words[idx], exp);
   endtask

   initial begin
      int  n0;
      bit  ok;
      logic [5:0] dt;
      hdr_valid_i = 1'b0;
      hdr_vc_i    = '0;
      hdr_dt_i    = '0;
      hdr_wc_i    = '0;
      pld_data_i  = '0;
      pld_valid_i = 1'b0;
      ready_i     = 1'b1;
      exp_keep    = 4'hF;
      exp_last    = 1'b0;
      rst_n       = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_valid", valid_o, 0);
      check("rst_last", last_o, 0);
      check("rst_data", data_o, 0);
      check("rst_keep", keep_o, 0);
      check("rst_hdr_ready", hdr_ready_o, 0);
      check("rst_pld_ready", pld_ready_o, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("rel_hdr_ready", hdr_ready_o, 1);

      // Short packet and all-zero header.
      n0 = out_words.size();
      send_pkt(2'd0, 6'h01, 16'h0000, 1'b0);
      drain();
      expect_word("short_word", n0, {32'h07000001, 4'hF, 1'b1});
      n0 = out_words.size();
      send_pkt(2'd0, 6'h00, 16'h0000, 1'b0);
      drain();
      expect_word("zero_word", n0, {32'h00000000, 4'hF, 1'b1});

      // Long packet with 5 bytes, 5-cycle downstream stall mid-payload.
      ready_mode = 2;
      ready_i    = 1'b1;
      n0 = out_words.size();
      send_pkt(2'd0, 6'h2B, 16'h0005, 1'b1);
      drain();
      check("long_nwords", out_words.size() - n0, 3);
      expect_word("long_hdr", n0, {32'h2E00052B, 4'hF, 1'b0});
      if (out_words.size() > n0 + 2) begin
         check("long_w1_ctl", out_words[n0+1][4:0], {4'hF, 1'b0});
         check("long_w2_ctl", out_words[n0+2][4:0], {4'h1, 1'b1});
      end
      ready_mode = 0;

      // Payload offered outside PLD must be refused.
      @(posedge clk);
      #1;
      pld_data_i  = 32'hDEADBEEF;
      pld_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_pld_ready", pld_ready_o, 0);
      end
      @(posedge clk);
      #1 pld_valid_i = 1'b0;

      // Data-type and word-count boundaries.
      send_pkt(2'd1, 6'h0F, 16'h0005, 1'b0);
      send_pkt(2'd2, 6'h10, 16'h0001, 1'b0);
      send_pkt(2'd3, 6'h3F, 16'h0004, 1'b0);
      send_pkt(2'd1, 6'h12, 16'h0006, 1'b0);
      send_pkt(2'd0, 6'h2A, 16'h0007, 1'b0);
      send_pkt(2'd2, 6'h24, 16'h0000, 1'b0);
      drain();

      // Back-to-back short packets leave no output bubble.
      n0 = out_cyc.size();
      send_pkt(2'd0, 6'h01, 16'h1234, 1'b0);
      send_pkt(2'd1, 6'h02, 16'hABCD, 1'b0);
      send_pkt(2'd2, 6'h03, 16'hFFFF, 1'b0);
      drain();
      check("b2b_count", out_cyc.size() - n0, 3);
      if (out_cyc.size() > n0 + 2) check("b2b_gap", out_cyc[n0+2] - out_cyc[n0], 2);

      // Reset asserted with a long packet in flight.
      hdr_vc_i    = 2'd0;
      hdr_dt_i    = 6'h2B;
      hdr_wc_i    = 16'h0005;
      hdr_valid_i = 1'b1;
      wait_hs(1'b1, ok);
      hdr_valid_i = 1'b0;
      check("mid_hdr_accept", ok, 1);
      pld_data_i  = $urandom;
      exp_keep    = 4'hF;
      exp_last    = 1'b0;
      pld_valid_i = 1'b1;
      wait_hs(1'b0, ok);
      pld_valid_i = 1'b0;
      check("mid_pld_accept", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_data", data_o, 0);
      check("mid_rst_keep", keep_o, 0);
      check("mid_rst_hdr_ready", hdr_ready_o, 0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("mid_rel_hdr_ready", hdr_ready_o, 1);
      n0 = out_words.size();
      send_pkt(2'd0, 6'h01, 16'h0000, 1'b0);
      drain();
      check("post_rst_nwords", out_words.size() - n0, 1);
      expect_word("post_rst_word", n0, {32'h07000001, 4'hF, 1'b1});

      // Largest counts: 16384 payload words through the 14-bit counter.
      n0 = out_words.size();
      send_pkt(2'd3, 6'h3F, 16'hFFFD, 1'b0);
      drain();
      check("max_nwords", out_words.size() - n0, 16385);

      // Random traffic with random downstream backpressure.
      ready_mode = 1;
      for (int i = 0; i < 1500; i++) begin
         dt = 6'($urandom_range(0, 63));
         send_pkt(2'($urandom_range(0, 3)), dt,
                  (dt >= LONG_DT_MIN) ? 16'($urandom_range(0, 40)) : 16'($urandom), 1'b0);
      end
      ready_mode = 0;
      drain();
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
